// File: rtl/if_id_registro.sv
// IF/ID pipeline register with load-use stall, branch flush and
// instruction-memory wait handling, plus a sticky wait-timeout watchdog.
module if_id_registro #(
  parameter int LARGURA      = 32,
  parameter int MAX_ESPERA   = 8,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    resetn,
  input  logic [LARGURA-1:0]      pcMais4,
  input  logic [LARGURA-1:0]      instrucao,
  input  logic                    instrPronta,
  input  logic                    desvioTomado,
  input  logic                    idexLerMem,
  input  logic [4:0]              idexRt,
  output logic                    PCescreve,
  output logic                    bolha,
  output logic [LARGURA-1:0]      ifidInstr,
  output logic [LARGURA-1:0]      ifidPC4,
  output logic                    ifidValido,
  output logic                    erroTimeout,
  output logic [LARGURA_CONT-1:0] contagemBolhas
);

  typedef enum logic [1:0] {
    ACAO_CARGA,
    ACAO_ESPERA,
    ACAO_BOLHA,
    ACAO_DESCARTE
  } acao_t;

  localparam logic [7:0] LIMITE_ESPERA = 8'(MAX_ESPERA);

  logic [LARGURA-1:0]      instr_q, instr_d;
  logic [LARGURA-1:0]      pc4_q, pc4_d;
  logic                    valido_q, valido_d;
  logic [7:0]              espera_q, espera_d;
  logic                    erro_q, erro_d;
  logic [LARGURA_CONT-1:0] cont_q, cont_d;

  logic [4:0] rs, rt;
  logic       perigo;
  acao_t      acao;

  assign rs     = instr_q[25:21];
  assign rt     = instr_q[20:16];
  assign perigo = valido_q & idexLerMem & (idexRt != 5'd0) &
                  ((idexRt == rs) | (idexRt == rt));

  always_comb begin
    if (desvioTomado)      acao = ACAO_DESCARTE;
    else if (perigo)       acao = ACAO_BOLHA;
    else if (!instrPronta) acao = ACAO_ESPERA;
    else                   acao = ACAO_CARGA;
  end

  // Fetch-facing controls are forced low while the pipeline is held in reset.
  assign PCescreve = resetn & ((acao == ACAO_CARGA) | (acao == ACAO_DESCARTE));
  assign bolha     = resetn & (acao == ACAO_BOLHA);

  always_comb begin
    instr_d  = instr_q;
    pc4_d    = pc4_q;
    valido_d = valido_q;
    espera_d = espera_q;
    cont_d   = cont_q;
    unique case (acao)
      ACAO_DESCARTE: begin
        instr_d  = '0;
        pc4_d    = '0;
        valido_d = 1'b0;
        espera_d = 8'd0;
      end
      ACAO_BOLHA: begin
        if (!(&cont_q)) cont_d = cont_q + LARGURA_CONT'(1);
      end
      ACAO_ESPERA: begin
        instr_d  = '0;
        valido_d = 1'b0;
        if (espera_q < LIMITE_ESPERA) espera_d = espera_q + 8'd1;
      end
      default: begin
        instr_d  = instrucao;
        pc4_d    = pcMais4;
        valido_d = 1'b1;
        espera_d = 8'd0;
      end
    endcase
    erro_d = erro_q | (espera_d == LIMITE_ESPERA);
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      instr_q  <= '0;
      pc4_q    <= '0;
      valido_q <= 1'b0;
      espera_q <= 8'd0;
      erro_q   <= 1'b0;
      cont_q   <= '0;
    end else begin
      instr_q  <= instr_d;
      pc4_q    <= pc4_d;
      valido_q <= valido_d;
      espera_q <= espera_d;
      erro_q   <= erro_d;
      cont_q   <= cont_d;
    end
  end

  assign ifidInstr      = instr_q;
  assign ifidPC4        = pc4_q;
  assign ifidValido     = valido_q;
  assign erroTimeout    = erro_q;
  assign contagemBolhas = cont_q;

endmodule
